bincnt_seq: RTL and testbench
=============================

// Module: bincnt_seq
// PURPOSE
//  Sequential, parametrised population counter / bit sorter for W-bit words.
//  Consumes CHUNK bits per clock and returns the binary count of ones (cnt) and the
//  sorted (thermometer) form of the input (y = ones packed into the LSBs).
//  Valid/ready handshake on both sides; sits between a word source and any
//  consumer needing ones-count or bit-sorted data without a W-wide adder tree.
// PARAMETERS
//  W      16  input word width; W >= 2
//  CHUNK  4   bits consumed per BUSY cycle; 1 <= CHUNK <= W, W % CHUNK == 0
//  EARLY  1   1: finish as soon as the unconsumed bits are all zero; 0: fixed latency
//  (derived) N = W/CHUNK chunk steps; CW = $clog2(W+1) count width
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   x holds a word to accept
//  in_ready   out  1   block can accept a word (high only in IDLE)
//  x          in   W   input word
//  out_valid  out  1   cnt/y hold a finished result
//  out_ready  in   1   consumer takes the result
//  cnt        out  CW  number of ones in the accepted word, 0..W
//  y          out  W   sorted word: y = (1 << cnt) - 1 (y = all ones when cnt = W)
// BEHAVIOUR
//  Reset (async, any state): state = IDLE; in_ready = 0 while rst = 1;
//   out_valid, cnt, y, shift register, accumulator and step counter = 0.
//   in_ready = 1 on the first clock after rst is released.
//  FSM states: IDLE, BUSY and DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
//  IDLE: on in_valid & in_ready: sh <= x, acc <= 0, step <= 0, go to BUSY.
//   Otherwise stay in IDLE.
//  BUSY, one step per clock:
//   - acc <= acc + popcount(sh[CHUNK-1:0])
//   - sh <= sh >> CHUNK
//   - step <= step + 1
//   Go to DONE when step == N-1, or when EARLY = 1 and (sh >> CHUNK) == 0.
//   On entry to DONE, register cnt = final acc and y = thermometer(final acc).
//  DONE: cnt and y stay stable until out_valid & out_ready, then go to IDLE.
//   There is no bypass from DONE to IDLE within the same cycle.
//  Latency: the word is accepted at edge E0; out_valid rises after edge E0+k.
//   k = N when EARLY = 0.
//   k = max(1, index of the highest nonzero chunk + 1) when EARLY = 1.
//  Throughput: at most one word per (k + 2) cycles; no overlap of words.
//  in_valid while BUSY or DONE is ignored; x is not sampled outside the accept cycle.
//  Widths: acc and cnt are CW bits and never overflow (max W). Chunk popcount is
//   zero-extended to CW before the add.
//  Reset mid-BUSY or mid-DONE: the word is dropped and no out_valid is produced.
//  Holding out_ready = 1 permanently gives a single-cycle out_valid pulse per word.
// TESTING (W=16, CHUNK=4 unless stated; k counted from accept edge)
//  1 x=16'h0000, EARLY=1 -> k=1, cnt=0, y=16'h0000; EARLY=0 -> k=4, same result
//  2 x=16'hFFFF -> k=4, cnt=16, y=16'hFFFF; x=16'h000F, EARLY=1 -> k=1, cnt=4, y=16'h000F
//  3 x=16'h8001, EARLY=1 -> k=4, cnt=2, y=16'h0003; x=16'h0030 -> k=2, cnt=2, y=16'h0003
//  4 x=16'h00F0, out_ready held low 5 cycles -> out_valid=1 and cnt=4 stable,
//    in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle
//  5 rst pulse 2 cycles after acceptance of 16'hFFFF -> outputs 0 immediately
//    (async), no out_valid afterwards; next word 16'h0101 -> cnt=2
//  6 W=4, CHUNK in {1,2,4}, EARLY in {0,1}: sweep x=0..15 -> cnt equals the sum of
//    the bits of x and y = (1<<cnt)-1 for all 16 values; also check k per the latency rule

Source files
------------

// File: rtl/bincnt_seq.sv
// Sequential popcount and bit sorter. Consumes CHUNK bits per clock and returns the
// ones-count plus the thermometer-sorted word, with valid/ready handshakes on both sides.
module bincnt_seq #(
  parameter  int W     = 16,
  parameter  int CHUNK = 4,
  parameter  int EARLY = 1,
  localparam int N     = W / CHUNK,
  localparam int CW    = $clog2(W + 1),
  localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  x,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] cnt,
  output logic [W-1:0]  y
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  sh_q, sh_d, y_q, y_d;
  logic [CW-1:0] acc_q, acc_d, cnt_q, cnt_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] acc_nx;
  logic [W-1:0]  sh_nx;
  logic          fin;

  function automatic logic [CW-1:0] popc(input logic [CHUNK-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < CHUNK; i++) s = s + CW'(v[i]);
    return s;
  endfunction

  function automatic logic [W-1:0] therm(input logic [CW-1:0] a);
    logic [W-1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) t[i] = (i < int'(a));
    return t;
  endfunction

  always_comb begin
    acc_nx  = acc_q + popc(sh_q[CHUNK-1:0]);
    sh_nx   = sh_q >> CHUNK;
    // Early exit once the remaining unconsumed bits cannot add to the count.
    fin     = (step_q == SW'(N - 1)) || ((EARLY != 0) && (sh_nx == '0));
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      IDLE: if (in_valid) begin
        sh_d    = x;
        acc_d   = '0;
        step_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        acc_d  = acc_nx;
        sh_d   = sh_nx;
        step_d = step_q + 1'b1;
        if (fin) begin
          cnt_d   = acc_nx;
          y_d     = therm(acc_nx);
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign cnt       = cnt_q;
  assign y         = y_q;

endmodule

// File: tb/tb_bincnt_seq.sv
// Directed bench for bincnt_seq: W=16 with EARLY=1/0, backpressure, mid-flight reset,
// and a W=4 sweep over every CHUNK/EARLY combination.
module tb_bincnt_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic        iv_a = 1'b0, or_a = 1'b1, ir_a, ov_a;
  logic [15:0] x_a = '0, y_a;
  logic [4:0]  cnt_a;
  logic        iv_b = 1'b0, or_b = 1'b1, ir_b, ov_b;
  logic [15:0] x_b = '0, y_b;
  logic [4:0]  cnt_b;

  logic            iv4 = 1'b0;
  logic [3:0]      x4 = '0;
  logic [5:0]      ir4, ov4;
  logic [5:0][2:0] cnt4;
  logic [5:0][3:0] y4;

  bincnt_seq #(.W(16), .CHUNK(4), .EARLY(1)) u_a (
    .clk(clk), .rst(rst), .in_valid(iv_a), .in_ready(ir_a), .x(x_a),
    .out_valid(ov_a), .out_ready(or_a), .cnt(cnt_a), .y(y_a));

  bincnt_seq #(.W(16), .CHUNK(4), .EARLY(0)) u_b (
    .clk(clk), .rst(rst), .in_valid(iv_b), .in_ready(ir_b), .x(x_b),
    .out_valid(ov_b), .out_ready(or_b), .cnt(cnt_b), .y(y_b));

  for (genvar g = 0; g < 6; g++) begin : g_w4
    localparam int C = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
    bincnt_seq #(.W(4), .CHUNK(C), .EARLY(g / 3)) u (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4[g]), .x(x4),
      .out_valid(ov4[g]), .out_ready(1'b1), .cnt(cnt4[g]), .y(y4[g]));
  end

  // sel=0 drives the EARLY=1 instance, sel=1 the EARLY=0 instance
  task automatic send16(input bit sel, input logic [15:0] v, input int exp_cnt,
                        input logic [15:0] exp_y, input int exp_k, input string nm);
    int t, k;
    logic [4:0]  c;
    logic [15:0] yy;
    t = 0;
    @(negedge clk);
    while (!(sel ? ir_b : ir_a) && t < 50) begin @(negedge clk); t++; end
    checks++;
    if (!(sel ? ir_b : ir_a)) begin
      failures++; $display("FAIL %s in_ready timeout: got 0 want 1", nm);
    end
    if (sel) begin iv_b = 1'b1; x_b = v; end else begin iv_a = 1'b1; x_a = v; end
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
    k = 0;
    while (!(sel ? ov_b : ov_a) && k < 40) begin @(posedge clk); #1; k++; end
    c  = sel ? cnt_b : cnt_a;
    yy = sel ? y_b : y_a;
    checks++;
    if (k !== exp_k) begin failures++; $display("FAIL %s latency: got %0d want %0d", nm, k, exp_k); end
    checks++;
    if (c !== 5'(exp_cnt)) begin failures++; $display("FAIL %s cnt: got %0d want %0d", nm, c, exp_cnt); end
    checks++;
    if (yy !== exp_y) begin failures++; $display("FAIL %s y: got %h want %h", nm, yy, exp_y); end
    @(posedge clk); #1;
    checks++;
    if ((sel ? ov_b : ov_a) !== 1'b0) begin
      failures++; $display("FAIL %s out_valid pulse: got 1 want 0", nm);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ir_a !== 1'b0 || ir_b !== 1'b0 || ir4 !== 6'h00) begin
      failures++; $display("FAIL reset_in_ready: got %b%b %b want 00 000000", ir_a, ir_b, ir4);
    end
    checks++;
    if (ov_a !== 1'b0 || cnt_a !== 5'd0 || y_a !== 16'h0) begin
      failures++; $display("FAIL reset_outputs: got ov=%b cnt=%0d y=%h want 0 0 0000", ov_a, cnt_a, y_a);
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (ir_a !== 1'b1 || ir_b !== 1'b1 || ir4 !== 6'h3f) begin
      failures++; $display("FAIL release_in_ready: got %b%b %b want 11 111111", ir_a, ir_b, ir4);
    end
  endtask

  task automatic test_early();
    send16(1'b0, 16'h0000, 0,  16'h0000, 1, "early_zero");
    send16(1'b0, 16'hFFFF, 16, 16'hFFFF, 4, "early_ffff");
    send16(1'b0, 16'h000F, 4,  16'h000F, 1, "early_000f");
    send16(1'b0, 16'h8001, 2,  16'h0003, 4, "early_8001");
    send16(1'b0, 16'h0030, 2,  16'h0003, 2, "early_0030");
  endtask

  task automatic test_fixed();
    send16(1'b1, 16'h0000, 0,  16'h0000, 4, "fixed_zero");
    send16(1'b1, 16'hFFFF, 16, 16'hFFFF, 4, "fixed_ffff");
    send16(1'b1, 16'h0030, 2,  16'h0003, 4, "fixed_0030");
  endtask

  task automatic test_backpressure();
    int k;
    or_a = 1'b0;
    @(negedge clk);
    iv_a = 1'b1; x_a = 16'h00F0;
    @(posedge clk); #1;
    iv_a = 1'b0;
    k = 0;
    while (!ov_a && k < 40) begin @(posedge clk); #1; k++; end
    checks++;
    if (k !== 2) begin failures++; $display("FAIL bp_latency: got %0d want 2", k); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); iv_a = 1'b1; x_a = 16'hFFFF;
      @(posedge clk); #1;
      checks++;
      if (ov_a !== 1'b1 || cnt_a !== 5'd4 || y_a !== 16'h000F || ir_a !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d: got ov=%b cnt=%0d y=%h rdy=%b want 1 4 000f 0", i, ov_a, cnt_a, y_a, ir_a);
      end
    end
    @(negedge clk); iv_a = 1'b0; or_a = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_a !== 1'b0 || ir_a !== 1'b1) begin
      failures++; $display("FAIL bp_release: got ov=%b rdy=%b want 0 1", ov_a, ir_a);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    iv_a = 1'b1; x_a = 16'hFFFF;
    @(posedge clk); #1;
    iv_a = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if (ov_a !== 1'b0 || cnt_a !== 5'd0 || y_a !== 16'h0 || ir_a !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_async: got ov=%b cnt=%0d y=%h rdy=%b want 0 0 0000 0", ov_a, cnt_a, y_a, ir_a);
    end
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (ov_a) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL mid_rst_drop: got out_valid 1 want 0"); end
    send16(1'b0, 16'h0101, 2, 16'h0003, 3, "after_rst");
  endtask

  task automatic test_w4_sweep();
    int t, ec, ek, c, n, vi;
    int kk [6];
    logic [5:0] got;
    for (int v = 0; v < 16; v++) begin
      t = 0;
      @(negedge clk);
      while (ir4 !== 6'h3f && t < 50) begin @(negedge clk); t++; end
      iv4 = 1'b1; x4 = 4'(v);
      @(posedge clk); #1;
      iv4 = 1'b0;
      got = '0;
      vi = v;
      ec = 0;
      for (int b = 0; b < 4; b++) ec += (vi >> b) & 1;
      for (int s = 1; s <= 10 && got != 6'h3f; s++) begin
        @(posedge clk); #1;
        for (int g = 0; g < 6; g++) begin
          if (ov4[g] && !got[g]) begin
            got[g] = 1'b1;
            kk[g]  = s;
            checks++;
            if (cnt4[g] !== 3'(ec) || y4[g] !== 4'((1 << ec) - 1)) begin
              failures++;
              $display("FAIL w4 g%0d x=%0d: got cnt=%0d y=%h want %0d %h", g, v, cnt4[g], y4[g], ec, 4'((1 << ec) - 1));
            end
          end
        end
      end
      for (int g = 0; g < 6; g++) begin
        c  = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
        n  = 4 / c;
        ek = n;
        if (g >= 3) begin
          ek = 1;
          for (int j = 0; j < n; j++) if (((vi >> (j * c)) & ((1 << c) - 1)) != 0) ek = j + 1;
        end
        checks++;
        if (!got[g] || kk[g] !== ek) begin
          failures++;
          $display("FAIL w4_lat g%0d x=%0d: got %0d (seen=%b) want %0d", g, v, got[g] ? kk[g] : -1, got[g], ek);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_early();
    test_fixed();
    test_backpressure();
    test_reset_mid();
    test_w4_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
